// File: rtl/fixed_dot_accumulator.sv
// Accumulates Q16.16 partial dot products per vector and emits one saturated result per vector.
// Optional build macro FIXED_DOT_ACC_RELU_EN clamps negative results to zero (activation stage).
module fixed_dot_accumulator #(
  parameter int DATA_W  = 32,
  parameter int ACC_W   = 48,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_in_valid,
  input  logic              io_in_last,
  output logic              io_in_ready,
  input  logic [DATA_W-1:0] io_psum,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [DATA_W-1:0] io_out_bits,
  output logic [CNT_W-1:0]  io_out_count,
  output logic              io_out_sat
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [1:0]              state;
  logic [LATENCY-1:0]      valid_pipe;
  logic [LATENCY-1:0]      last_pipe;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        count_next;
  logic                    blocked;
  logic                    issue;
  logic                    d_valid;
  logic                    d_last;
  logic                    handshake;
  logic [DATA_W-1:0]       result;
  logic                    result_sat;

  assign io_in_ready = !blocked;
  assign issue       = io_in_valid && io_in_ready;
  assign d_valid     = valid_pipe[LATENCY-1];
  assign d_last      = last_pipe[LATENCY-1];
  assign handshake   = io_out_valid && io_out_ready;
  assign sum         = acc + {{(ACC_W-DATA_W){io_psum[DATA_W-1]}}, io_psum};
  assign count_next  = (count == '1) ? count : count + CNT_W'(1);

  always_comb begin
    result     = sum[DATA_W-1:0];
    result_sat = 1'b0;
    if (sum > SAT_MAX) begin
      result     = {1'b0, {(DATA_W-1){1'b1}}};
      result_sat = 1'b1;
    end else if (sum < SAT_MIN) begin
      result     = {1'b1, {(DATA_W-1){1'b0}}};
      result_sat = 1'b1;
    end
`ifdef FIXED_DOT_ACC_RELU_EN
    if (result[DATA_W-1]) begin
      result = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      valid_pipe   <= '0;
      last_pipe    <= '0;
      acc          <= '0;
      count        <= '0;
      blocked      <= 1'b0;
      io_out_valid <= 1'b0;
      io_out_bits  <= '0;
      io_out_count <= '0;
      io_out_sat   <= 1'b0;
    end else begin
      valid_pipe[0] <= issue;
      last_pipe[0]  <= issue && io_in_last;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
        last_pipe[i]  <= last_pipe[i-1];
      end

      // The dot-product pipeline cannot stall, so issue closes once a last is taken
      // and stays closed until the held result is consumed.
      if (issue && io_in_last) begin
        blocked <= 1'b1;
      end else if (handshake) begin
        blocked <= 1'b0;
      end

      case (state)
        IDLE, ACCUM: begin
          if (d_valid) begin
            acc   <= sum;
            count <= count_next;
            if (d_last) begin
              state        <= HOLD;
              io_out_valid <= 1'b1;
              io_out_bits  <= result;
              io_out_count <= count_next;
              io_out_sat   <= result_sat;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (handshake) begin
            state        <= IDLE;
            io_out_valid <= 1'b0;
            acc          <= '0;
            count        <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_dot_accumulator.sv
// Directed bench for fixed_dot_accumulator; psum is fed LAT cycles after each issue like the real stage.
module tb_fixed_dot_accumulator;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_last;
  logic        io_in_ready;
  logic [31:0] io_psum;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [31:0] io_out_bits;
  logic [7:0]  io_out_count;
  logic        io_out_sat;

  logic [31:0] vals [0:299];
  int n_cmp = 0;
  int n_err = 0;

  fixed_dot_accumulator #(
    .DATA_W (32),
    .ACC_W  (48),
    .LATENCY(LAT),
    .CNT_W  (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .io_in_valid (io_in_valid),
    .io_in_last  (io_in_last),
    .io_in_ready (io_in_ready),
    .io_psum     (io_psum),
    .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready),
    .io_out_bits (io_out_bits),
    .io_out_count(io_out_count),
    .io_out_sat  (io_out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] act(input logic [31:0] b);
`ifdef FIXED_DOT_ACC_RELU_EN
    return b[31] ? 32'h0 : b;
`else
    return b;
`endif
  endfunction

  // Called at a negedge; issues vals[0..n-1] back-to-back and checks the result timing.
  task automatic send_vec(input int n, input logic [31:0] eb, input logic [7:0] ec, input logic es);
    for (int c = 0; c < n + LAT; c++) begin
      check("in_ready", io_in_ready, c < n);
      check("out_valid_early", io_out_valid, 1'b0);
      io_in_valid = (c < n);
      io_in_last  = (c == n - 1);
      io_psum     = (c >= LAT) ? vals[c-LAT] : 32'h0;
      @(negedge clk);
    end
    io_in_valid = 1'b0;
    io_in_last  = 1'b0;
    io_psum     = 32'h0;
    check("out_valid", io_out_valid, 1'b1);
    check("out_bits", io_out_bits, eb);
    check("out_count", io_out_count, ec);
    check("out_sat", io_out_sat, es);
    check("in_ready_hold", io_in_ready, 1'b0);
  endtask

  task automatic drain();
    io_out_ready = 1'b1;
    @(negedge clk);
    io_out_ready = 1'b0;
    check("drain_valid", io_out_valid, 1'b0);
    check("drain_ready", io_in_ready, 1'b1);
  endtask

  initial begin
    reset        = 1'b1;
    io_in_valid  = 1'b0;
    io_in_last   = 1'b0;
    io_psum      = 32'h0;
    io_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", io_out_valid, 1'b0);
    check("rst_bits", io_out_bits, 32'h0);
    check("rst_count", io_out_count, 8'h0);
    check("rst_sat", io_out_sat, 1'b0);
    check("rst_ready", io_in_ready, 1'b1);
    reset = 1'b0;
    @(negedge clk);

    // Reset while accumulating with two chunks still in the pipe
    for (int c = 0; c < 3; c++) begin
      io_in_valid = 1'b1;
      io_in_last  = 1'b0;
      io_psum     = (c >= LAT) ? 32'h0007_0000 : 32'h0;
      @(negedge clk);
    end
    io_in_valid = 1'b0;
    io_psum     = 32'h0;
    reset       = 1'b1;
    #2;
    check("midrst_valid", io_out_valid, 1'b0);
    check("midrst_ready", io_in_ready, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("no_stale", io_out_valid, 1'b0);
    vals[0] = 32'h0001_0000;
    send_vec(1, 32'h0001_0000, 8'd1, 1'b0);
    drain();

    // Three chunks: 1.0 + 2.0 - 1.0
    vals[0] = 32'h0001_0000; vals[1] = 32'h0002_0000; vals[2] = 32'hFFFF_0000;
    send_vec(3, 32'h0002_0000, 8'd3, 1'b0);
    drain();

    // Most negative single value with consumer already ready
    vals[0] = 32'h8000_0000;
    io_out_ready = 1'b1;
    send_vec(1, act(32'h8000_0000), 8'd1, 1'b0);
    drain();

    for (int i = 0; i < 4; i++) vals[i] = 32'h7FFF_FFFF;
    send_vec(4, 32'h7FFF_FFFF, 8'd4, 1'b1);
    drain();
    for (int i = 0; i < 4; i++) vals[i] = 32'h8000_0000;
    send_vec(4, act(32'h8000_0000), 8'd4, 1'b1);
    drain();

    // Backpressure with issue attempts during HOLD
    vals[0] = 32'h0003_0000;
    send_vec(1, 32'h0003_0000, 8'd1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      io_in_valid = 1'b1;
      io_in_last  = 1'b1;
      @(negedge clk);
      check("bp_ready", io_in_ready, 1'b0);
      check("bp_valid", io_out_valid, 1'b1);
      check("bp_bits", io_out_bits, 32'h0003_0000);
      check("bp_count", io_out_count, 8'd1);
    end
    drain();
    vals[0] = 32'h0005_0000;
    send_vec(1, 32'h0005_0000, 8'd1, 1'b0);
    drain();

    // Negative result: -3.0
    for (int i = 0; i < 3; i++) vals[i] = 32'hFFFF_0000;
    send_vec(3, act(32'hFFFD_0000), 8'd3, 1'b0);
    drain();

    // Chunk counter saturates at 255
    for (int i = 0; i < 256; i++) vals[i] = 32'h0000_0001;
    send_vec(256, 32'h0000_0100, 8'd255, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
